// File: rtl/pingpong_ctrl.sv
// pingpong_ctrl
//   Address sequencer for a two-bank ping-pong buffer held in an external
//   memory. The writer fills one bank while the reader drains the other.
//   Banks are handed over in commit order. A bank that is committed or freed
//   becomes visible to the other side on the following cycle. This block only
//   produces addresses and strobes. Read data latency belongs to the memory.
//
// Parameters
//   DEPTH      entries per bank
//   AW         external memory address width (2*DEPTH <= 2**AW)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-low
//   wr_valid   writer presents one byte this cycle
//   wr_flush   writer commits the partially filled bank
//   wr_ready   current write bank accepts a byte
//   mem_we     external memory write strobe
//   mem_waddr  external memory write address
//   rd_ready   reader consumes the current entry
//   rd_valid   current read bank holds committed data
//   rd_last    current entry is the last of its bank
//   mem_raddr  external memory read address
//   full       no bank writable
//   empty      no bank readable
//   ovf        sticky: write attempted while not ready
module pingpong_ctrl #(
  parameter int DEPTH = 3,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_valid,
  input  logic          wr_flush,
  output logic          wr_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  input  logic          rd_ready,
  output logic          rd_valid,
  output logic          rd_last,
  output logic [AW-1:0] mem_raddr,
  output logic          full,
  output logic          empty,
  output logic          ovf
);

  // Offsets and lengths share one width wide enough to hold DEPTH itself.
  localparam int            OW         = $clog2(DEPTH + 1);
  localparam logic [OW-1:0] LAST_OFF   = OW'(DEPTH - 1);
  localparam logic [OW-1:0] ONE        = OW'(1);
  localparam logic [AW-1:0] BANK1_BASE = AW'(DEPTH);

  typedef enum logic [1:0] {
    FREE     = 2'd0,
    FILLING  = 2'd1,
    READY    = 2'd2,
    DRAINING = 2'd3
  } bank_st_t;

  bank_st_t      st0, st1, st0_nxt, st1_nxt;
  logic [OW-1:0] len0, len1, len0_nxt, len1_nxt;
  logic          wr_bank, wr_bank_nxt;
  logic          rd_bank, rd_bank_nxt;
  logic [OW-1:0] wr_off, wr_off_nxt;
  logic [OW-1:0] rd_off, rd_off_nxt;
  logic          ovf_nxt;

  bank_st_t      wr_st, rd_st;
  logic [OW-1:0] rd_len;
  logic          rd_acc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st0     <= FREE;
      st1     <= FREE;
      len0    <= '0;
      len1    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_off  <= '0;
      rd_off  <= '0;
      ovf     <= 1'b0;
    end else begin
      st0     <= st0_nxt;
      st1     <= st1_nxt;
      len0    <= len0_nxt;
      len1    <= len1_nxt;
      wr_bank <= wr_bank_nxt;
      rd_bank <= rd_bank_nxt;
      wr_off  <= wr_off_nxt;
      rd_off  <= rd_off_nxt;
      ovf     <= ovf_nxt;
    end
  end

  always_comb begin
    st0_nxt     = st0;
    st1_nxt     = st1;
    len0_nxt    = len0;
    len1_nxt    = len1;
    wr_bank_nxt = wr_bank;
    rd_bank_nxt = rd_bank;
    wr_off_nxt  = wr_off;
    rd_off_nxt  = rd_off;

    // Outputs depend on registers only, plus the request inputs for mem_we.
    wr_st     = wr_bank ? st1 : st0;
    rd_st     = rd_bank ? st1 : st0;
    rd_len    = rd_bank ? len1 : len0;
    wr_ready  = (wr_st == FREE) || (wr_st == FILLING);
    full      = !wr_ready;
    mem_we    = wr_valid && wr_ready;
    mem_waddr = (wr_bank ? BANK1_BASE : '0) + AW'(wr_off);
    rd_valid  = (rd_st == READY) || (rd_st == DRAINING);
    empty     = !rd_valid;
    rd_last   = rd_valid && (rd_off == rd_len - ONE);
    mem_raddr = (rd_bank ? BANK1_BASE : '0) + AW'(rd_off);
    rd_acc    = rd_valid && rd_ready;
    ovf_nxt   = ovf || (wr_valid && !wr_ready);

    // Write side. The write bank is always FREE/FILLING when it acts and the
    // read bank always READY/DRAINING, so the two sides never touch the same
    // bank in one cycle.
    if (mem_we) begin
      if (wr_off == LAST_OFF || wr_flush) begin
        if (wr_bank) begin
          st1_nxt  = READY;
          len1_nxt = wr_off + ONE;
        end else begin
          st0_nxt  = READY;
          len0_nxt = wr_off + ONE;
        end
        wr_bank_nxt = !wr_bank;
        wr_off_nxt  = '0;
      end else begin
        if (wr_bank) st1_nxt = FILLING;
        else         st0_nxt = FILLING;
        wr_off_nxt = wr_off + ONE;
      end
    end else if (wr_flush && wr_st == FILLING) begin
      // A FILLING bank always holds at least one entry, so len >= 1 here.
      if (wr_bank) begin
        st1_nxt  = READY;
        len1_nxt = wr_off;
      end else begin
        st0_nxt  = READY;
        len0_nxt = wr_off;
      end
      wr_bank_nxt = !wr_bank;
      wr_off_nxt  = '0;
    end

    // Read side.
    if (rd_acc) begin
      if (rd_last) begin
        if (rd_bank) st1_nxt = FREE;
        else         st0_nxt = FREE;
        rd_bank_nxt = !rd_bank;
        rd_off_nxt  = '0;
      end else begin
        if (rd_bank) st1_nxt = DRAINING;
        else         st0_nxt = DRAINING;
        rd_off_nxt = rd_off + ONE;
      end
    end
  end

endmodule

// File: tb/tb_pingpong_ctrl.sv
// tb_pingpong_ctrl
//   Self-checking bench for pingpong_ctrl. A queue-based model of committed
//   banks is compared with the DUT every cycle. Directed scenarios pin the
//   model with literal expectations. Randomized traffic follows, with
//   occasional reset pulses.
module tb_pingpong_ctrl;
  localparam int DEPTH = 3;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_valid = 1'b0;
  logic          wr_flush = 1'b0;
  logic          rd_ready = 1'b0;
  logic          wr_ready, mem_we, rd_valid, rd_last, full, empty, ovf;
  logic [AW-1:0] mem_waddr, mem_raddr;

  pingpong_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_flush(wr_flush), .wr_ready(wr_ready),
    .mem_we(mem_we), .mem_waddr(mem_waddr),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_last(rd_last),
    .mem_raddr(mem_raddr), .full(full), .empty(empty), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: committed bank lengths in commit order, the fill count of the
  // uncommitted bank, the read position in the head bank, and which physical
  // bank each side uses.
  int q[$];
  int fill  = 0;
  int rpos  = 0;
  int wbank = 0;
  int rbank = 0;
  bit m_ovf = 0;

  always @(posedge clk or negedge rst) begin : model
    bit can_wr, acc, rd, rlast;
    if (!rst) begin
      q.delete();
      fill = 0; rpos = 0; wbank = 0; rbank = 0; m_ovf = 0;
    end else begin
      can_wr = (q.size() < 2);
      acc    = wr_valid && can_wr;
      rd     = (q.size() > 0) && rd_ready;
      rlast  = rd && (rpos == q[0] - 1);
      if (wr_valid && !can_wr) m_ovf = 1;
      if (acc) begin
        if (fill + 1 == DEPTH || wr_flush) begin
          q.push_back(fill + 1); fill = 0; wbank = 1 - wbank;
        end else fill++;
      end else if (wr_flush && can_wr && fill > 0) begin
        q.push_back(fill); fill = 0; wbank = 1 - wbank;
      end
      if (rd) begin
        if (rlast) begin
          void'(q.pop_front()); rpos = 0; rbank = 1 - rbank;
        end else rpos++;
      end
    end
  end

  always @(negedge clk) begin : compare
    int e_wr, e_rv, e_last;
    e_wr   = (q.size() < 2);
    e_rv   = (q.size() > 0);
    e_last = e_rv && (rpos == q[0] - 1);
    chk("wr_ready", wr_ready, e_wr);
    chk("full", full, !e_wr);
    chk("mem_we", mem_we, wr_valid && e_wr);
    chk("mem_waddr", mem_waddr, wbank * DEPTH + fill);
    chk("rd_valid", rd_valid, e_rv);
    chk("empty", empty, !e_rv);
    chk("rd_last", rd_last, e_last);
    chk("mem_raddr", mem_raddr, rbank * DEPTH + rpos);
    chk("ovf", ovf, m_ovf);
  end

  task automatic set_in(bit v, bit f, bit r);
    @(posedge clk); #1;
    wr_valid = v; wr_flush = f; rd_ready = r;
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_wr_ready"}, wr_ready, 1);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_rd_last"}, rd_last, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_waddr"}, mem_waddr, 0);
    chk({tag, "_raddr"}, mem_raddr, 0);
    chk({tag, "_ovf"}, ovf, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 0; wr_valid = 0; wr_flush = 0; rd_ready = 0;
    @(negedge clk);
    chk_reset_vals("rst");
    @(posedge clk); #1;
    rst = 1;
  endtask

  initial begin
    #1 rst = 0;
    @(negedge clk);
    chk_reset_vals("por");
    @(posedge clk); #1 rst = 1;

    // Three writes fill bank 0; it is readable the next cycle.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(1, 0, 0); @(negedge clk);
      chk("w3_addr", mem_waddr, i); chk("w3_we", mem_we, 1);
    end
    set_in(0, 0, 0); @(negedge clk);
    chk("w3_rd_valid", rd_valid, 1); chk("w3_next_addr", mem_waddr, 3);
    set_in(1, 0, 0); @(negedge clk);
    chk("w3_addr3", mem_waddr, 3); chk("w3_we3", mem_we, 1);

    // Six writes fill both banks, then overflow.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_in(1, 0, 0); @(negedge clk);
      chk("w6_addr", mem_waddr, i);
    end
    set_in(0, 0, 0); @(negedge clk);
    chk("w6_full", full, 1);
    set_in(1, 0, 0); @(negedge clk);
    chk("w6_ovf_we", mem_we, 0);
    set_in(0, 0, 0); @(negedge clk);
    chk("w6_ovf", ovf, 1);

    // Drain both banks back to back.
    for (int i = 0; i < 6; i++) begin
      set_in(0, 0, 1); @(negedge clk);
      chk("rd6_addr", mem_raddr, i);
      chk("rd6_last", rd_last, (i == 2 || i == 5) ? 1 : 0);
      chk("rd6_valid", rd_valid, 1);
    end
    set_in(0, 0, 0); @(negedge clk);
    chk("rd6_empty", empty, 1);

    // Two writes then a flush commit a short bank.
    do_reset();
    set_in(1, 0, 0); @(negedge clk); chk("fl_a0", mem_waddr, 0);
    set_in(1, 0, 0); @(negedge clk); chk("fl_a1", mem_waddr, 1);
    set_in(0, 1, 0); @(negedge clk);
    chk("fl_we", mem_we, 0); chk("fl_rv0", rd_valid, 0);
    set_in(1, 0, 1); @(negedge clk);
    chk("fl_waddr", mem_waddr, 3); chk("fl_r0", mem_raddr, 0);
    chk("fl_last0", rd_last, 0); chk("fl_rv", rd_valid, 1);
    set_in(0, 0, 1); @(negedge clk);
    chk("fl_r1", mem_raddr, 1); chk("fl_last1", rd_last, 1);
    set_in(0, 0, 0); @(negedge clk);
    chk("fl_empty", empty, 1);

    // Write plus flush in the same cycle gives len = 2.
    do_reset();
    set_in(1, 0, 0); @(negedge clk); chk("wf_a0", mem_waddr, 0);
    set_in(1, 1, 0); @(negedge clk);
    chk("wf_a1", mem_waddr, 1); chk("wf_we", mem_we, 1);
    set_in(0, 0, 1); @(negedge clk);
    chk("wf_r0", mem_raddr, 0); chk("wf_last0", rd_last, 0);
    set_in(0, 0, 1); @(negedge clk);
    chk("wf_r1", mem_raddr, 1); chk("wf_last1", rd_last, 1);
    set_in(0, 0, 0); @(negedge clk);
    chk("wf_empty", empty, 1); chk("wf_waddr", mem_waddr, 3);

    // Asynchronous reset mid-operation discards everything at once.
    do_reset();
    for (int i = 0; i < 4; i++) set_in(1, 0, 0);
    @(posedge clk); #1;
    rst = 0; wr_valid = 0; wr_flush = 0; rd_ready = 0;
    #1;
    chk_reset_vals("async");
    @(posedge clk); #1 rst = 1;
    set_in(1, 0, 0); @(negedge clk);
    chk("async_addr", mem_waddr, 0); chk("async_we", mem_we, 1);

    // Randomized traffic, compared every cycle by the compare process.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      else set_in($urandom_range(0, 99) < 70,
                  $urandom_range(0, 99) < 12,
                  $urandom_range(0, 99) < ((n < 1500) ? 30 : 80));
    end

    set_in(0, 0, 0);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pingpong_ctrl.md
PINGPONG_CTRL -- requirements
Module: pingpong_ctrl

Interface
REQ-001 Parameter: DEPTH, default 3, entries per bank (two banks).
REQ-002 Parameter: AW, default 3, external memory address width; SHALL satisfy 2*DEPTH <= 2^AW.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 wr_valid  in  1  writer presents one byte this cycle.
REQ-006 wr_flush  in  1  writer commits the partially filled bank.
REQ-007 wr_ready  out  1  current write bank accepts a byte.
REQ-008 mem_we  out  1  external memory write strobe.
REQ-009 mem_waddr  out  AW  external memory write address.
REQ-010 rd_ready  in  1  reader consumes the current entry.
REQ-011 rd_valid  out  1  current read bank holds committed data.
REQ-012 rd_last  out  1  current entry is the last entry of its bank.
REQ-013 mem_raddr  out  AW  external memory read address.
REQ-014 full  out  1  no bank writable.
REQ-015 empty  out  1  no bank readable.
REQ-016 ovf  out  1  sticky: write attempted while not ready.

Function
REQ-017 Each bank SHALL hold a registered state: FREE, FILLING, READY, or DRAINING, plus a registered length len (0..DEPTH).
REQ-018 Registered wr_bank and rd_bank pointers SHALL each alternate 0,1,0,1, so banks are consumed in commit order.
REQ-019 wr_ready SHALL be 1 when state[wr_bank] is FREE or FILLING; full = !wr_ready; both combinational from registers.
REQ-020 mem_we SHALL be wr_valid & wr_ready (combinational); mem_waddr SHALL be wr_bank*DEPTH + wr_off.
REQ-021 On an accepted write, wr_off SHALL increment and a FREE bank SHALL become FILLING.
REQ-022 On an accepted write with wr_off == DEPTH-1, the bank SHALL become READY with len = DEPTH, wr_bank SHALL toggle, and wr_off SHALL clear.
REQ-023 wr_flush on a FILLING bank without a write SHALL commit it: READY, len = wr_off, wr_bank toggles, wr_off clears.
REQ-024 wr_flush together with an accepted write SHALL commit with len = wr_off+1; at wr_off == DEPTH-1 it is identical to REQ-022.
REQ-025 wr_flush on a FREE bank, or while wr_ready = 0, SHALL be ignored.
REQ-026 wr_valid while wr_ready = 0 SHALL NOT assert mem_we and SHALL set ovf; ovf stays set until reset.
REQ-027 rd_valid SHALL be 1 when state[rd_bank] is READY or DRAINING; empty = !rd_valid.
REQ-028 mem_raddr SHALL be rd_bank*DEPTH + rd_off; rd_last SHALL be rd_valid & (rd_off == len[rd_bank]-1).
REQ-029 On rd_valid & rd_ready, rd_off SHALL increment and READY SHALL become DRAINING.
REQ-030 On rd_valid & rd_ready & rd_last, the bank SHALL become FREE, rd_bank SHALL toggle, and rd_off SHALL clear.
REQ-031 A bank committed or freed in cycle N SHALL be visible to the other side in cycle N+1 (one-cycle handover, no combinational bypass).
REQ-032 Concurrent write to one bank and read from the other SHALL proceed every cycle without stalls.
REQ-033 Read data latency belongs to the external memory; this block only sequences addresses.

Reset
REQ-034 While rst = 0: both banks FREE, len = 0; wr_bank = rd_bank = 0; wr_off = rd_off = 0; ovf = 0.
REQ-035 Output values in reset: wr_ready = 1, full = 0, rd_valid = 0, empty = 1, rd_last = 0, mem_we = 0, mem_waddr = 0, mem_raddr = 0.
REQ-036 Reset asserted mid-operation SHALL discard all buffered content and uncommitted partial banks immediately.

Verification
REQ-037 Reset, then 3 writes -> mem_waddr 0,1,2; the next cycle has rd_valid = 1 and the next write goes to address 3.
REQ-038 6 writes with rd_ready = 0 -> addresses 0..5, then full = 1; a 7th wr_valid gives mem_we = 0 and ovf = 1.
REQ-039 Both banks full, rd_ready held 1 -> mem_raddr 0,1,2,3,4,5 on consecutive cycles; rd_last on 2 and 5; then empty = 1.
REQ-040 2 writes then wr_flush -> reads at 0,1 with rd_last on 1; the next write goes to address 3.
REQ-041 Write at offset 0, then write+flush in one cycle -> len = 2; reads 0,1; rd_last on 1.
REQ-042 rst pulsed low after 4 writes -> all REQ-035 values; the next write goes to address 0.
